frame_buffer_manager: RTL and testbench

Parametrised successor to the double-buffered display store: N_BUFFERS (2 or 3) pixel banks of H_RES x V_RES colour ids behind one writer port (renderer/NIOS PIO) and one reader port (VGA scan). It owns buffer rotation, swapping only on vertical blank. It optionally hardware-clears each newly acquired back buffer. It replaces the external select/swap/fb_we glue and the copy-based front buffer.

---
 rtl/frame_buffer_manager_if.sv | 38 +++
 rtl/frame_buffer_manager.sv | 187 ++++++++++++++++++
 tb/tb_frame_buffer_manager.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/frame_buffer_manager_if.sv
// Writer, reader and status bundle between a frame_buffer_manager and its
// client. The client (renderer + VGA scan) uses the master view and the
// manager uses the slave view.
interface frame_buffer_manager_if #(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int COLOR_BITS = 4
) ();
    localparam int DEPTH  = H_RES * V_RES;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int X_W    = $clog2(H_RES);
    localparam int Y_W    = $clog2(V_RES);
    localparam int IDX_W  = 2;

    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [COLOR_BITS-1:0] wr_data;
    logic                  frame_done;
    logic                  wr_ready;
    logic                  vblank;
    logic [X_W-1:0]        rd_x;
    logic [Y_W-1:0]        rd_y;
    logic [COLOR_BITS-1:0] rd_data;
    logic [IDX_W-1:0]      disp_idx;
    logic [IDX_W-1:0]      back_idx;
    logic                  swap_pulse;
    logic [15:0]           drop_count;

    modport master (
        output wr_en, wr_addr, wr_data, frame_done, vblank, rd_x, rd_y,
        input  wr_ready, rd_data, disp_idx, back_idx, swap_pulse, drop_count
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, frame_done, vblank, rd_x, rd_y,
        output wr_ready, rd_data, disp_idx, back_idx, swap_pulse, drop_count
    );
endinterface

// File: rtl/frame_buffer_manager.sv
// Double/triple-buffered pixel store. The writer owns bank back_idx, the VGA
// reader scans bank disp_idx, and banks rotate only on a vblank rising edge.
// A newly acquired back bank can optionally be flood-filled with CLEAR_COLOR.
module frame_buffer_manager #(
    parameter int H_RES       = 320,
    parameter int V_RES       = 240,
    parameter int COLOR_BITS  = 4,
    parameter int N_BUFFERS   = 2,
    parameter int CLEAR_EN    = 1,
    parameter int CLEAR_COLOR = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    frame_buffer_manager_if.slave  bus
);
    localparam int          DEPTH   = H_RES * V_RES;
    localparam int          ADDR_W  = $clog2(DEPTH);
    localparam int          IDX_W   = 2;
    localparam int          MEM_W   = $clog2(N_BUFFERS * DEPTH);
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);
    localparam logic [31:0] H_RES_U = 32'(H_RES);
    localparam logic [31:0] V_RES_U = 32'(V_RES);

    typedef enum logic [1:0] {
        ST_WRITE     = 2'd0,
        ST_WAIT_SWAP = 2'd1,
        ST_CLEAR     = 2'd2
    } state_e;

    // All banks live in one flat array; bank b occupies [b*DEPTH, b*DEPTH+DEPTH-1].
    function automatic logic [MEM_W-1:0] bank_addr(input logic [IDX_W-1:0]  bank,
                                                   input logic [ADDR_W-1:0] addr);
        return MEM_W'(bank) * MEM_W'(DEPTH) + MEM_W'(addr);
    endfunction

    logic [COLOR_BITS-1:0] mem_q [N_BUFFERS*DEPTH];

    state_e                state_q,   state_d;
    logic [IDX_W-1:0]      disp_q,    disp_d;
    logic [IDX_W-1:0]      back_q,    back_d;
    logic                  rdy_vld_q, rdy_vld_d;
    logic [IDX_W-1:0]      rdy_idx_q, rdy_idx_d;
    logic [15:0]           drop_q,    drop_d;
    logic [ADDR_W-1:0]     clr_q,     clr_d;
    logic                  vblank_q;
    logic                  swap_pulse_q;
    logic [COLOR_BITS-1:0] rd_data_q;

    logic                  vb_rise_s;
    logic                  mem_we_s;
    logic [MEM_W-1:0]      mem_waddr_s;
    logic [COLOR_BITS-1:0] mem_wdata_s;
    logic                  rd_in_range_s;
    logic [ADDR_W-1:0]     rd_addr_s;
    logic [MEM_W-1:0]      mem_raddr_s;

    assign vb_rise_s     = bus.vblank & ~vblank_q;
    assign rd_addr_s     = ADDR_W'(bus.rd_y) * ADDR_W'(H_RES) + ADDR_W'(bus.rd_x);
    assign rd_in_range_s = (32'(bus.rd_x) < H_RES_U) && (32'(bus.rd_y) < V_RES_U);
    assign mem_raddr_s   = rd_in_range_s ? bank_addr(disp_q, rd_addr_s) : {MEM_W{1'b0}};

    // Single write port: pixel writes in WRITE, flood fill in CLEAR, always into the back bank.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = bank_addr(back_q, bus.wr_addr);
        mem_wdata_s = bus.wr_data;
        if (state_q == ST_CLEAR) begin
            mem_we_s    = ~reset;
            mem_waddr_s = bank_addr(back_q, clr_q);
            mem_wdata_s = COLOR_BITS'(CLEAR_COLOR);
        end else if (state_q == ST_WRITE) begin
            mem_we_s = ~reset & bus.wr_en & (32'(bus.wr_addr) < DEPTH_U);
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Writer FSM and bank rotation; frame_done is applied before a same-cycle vblank edge.
    always_comb begin
        state_d   = state_q;
        disp_d    = disp_q;
        back_d    = back_q;
        rdy_vld_d = rdy_vld_q;
        rdy_idx_d = rdy_idx_q;
        drop_d    = drop_q;
        clr_d     = clr_q;

        case (state_q)
            ST_WRITE: begin
                if (bus.frame_done) begin
                    if (N_BUFFERS == 2) begin
                        state_d = ST_WAIT_SWAP;
                    end else begin
                        rdy_vld_d = 1'b1;
                        rdy_idx_d = back_q;
                        if (rdy_vld_q) begin
                            // Undisplayed frame is overwritten: recycle its bank.
                            back_d = rdy_idx_q;
                            drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
                        end else begin
                            back_d = 2'd3 - disp_q - back_q;
                        end
                        state_d = (CLEAR_EN != 0) ? ST_CLEAR : ST_WRITE;
                        clr_d   = {ADDR_W{1'b0}};
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WAIT_SWAP: begin
                state_d = ST_WAIT_SWAP;
            end
            ST_CLEAR: begin
                if (clr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_WRITE;
                    clr_d   = {ADDR_W{1'b0}};
                end else begin
                    clr_d = clr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_WRITE;
            end
        endcase

        if (vb_rise_s) begin
            if (N_BUFFERS == 2) begin
                if (state_d == ST_WAIT_SWAP) begin
                    disp_d  = back_q;
                    back_d  = disp_q;
                    state_d = (CLEAR_EN != 0) ? ST_CLEAR : ST_WRITE;
                    clr_d   = {ADDR_W{1'b0}};
                end else begin
                    disp_d = disp_q;
                end
            end else if (rdy_vld_d) begin
                disp_d    = rdy_idx_d;
                rdy_vld_d = 1'b0;
            end else begin
                disp_d = disp_q;
            end
        end else begin
            disp_d = disp_q;
        end
    end

    // Control state, status outputs and the registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_WRITE;
            disp_q       <= 2'd0;
            back_q       <= 2'd1;
            rdy_vld_q    <= 1'b0;
            rdy_idx_q    <= 2'd0;
            drop_q       <= 16'd0;
            clr_q        <= {ADDR_W{1'b0}};
            vblank_q     <= 1'b0;
            swap_pulse_q <= 1'b0;
            rd_data_q    <= {COLOR_BITS{1'b0}};
        end else begin
            state_q      <= state_d;
            disp_q       <= disp_d;
            back_q       <= back_d;
            rdy_vld_q    <= rdy_vld_d;
            rdy_idx_q    <= rdy_idx_d;
            drop_q       <= drop_d;
            clr_q        <= clr_d;
            vblank_q     <= bus.vblank;
            swap_pulse_q <= (disp_d != disp_q);
            rd_data_q    <= rd_in_range_s ? mem_q[mem_raddr_s] : {COLOR_BITS{1'b0}};
        end
    end

    // Pixel storage; contents are deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign bus.wr_ready   = (state_q == ST_WRITE);
    assign bus.rd_data    = rd_data_q;
    assign bus.disp_idx   = disp_q;
    assign bus.back_idx   = back_q;
    assign bus.swap_pulse = swap_pulse_q;
    assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_frame_buffer_manager.sv
// Directed bench for frame_buffer_manager: three instances cover the
// double-buffer, double-buffer-with-clear and triple-buffer configurations.
module tb_frame_buffer_manager;
    logic clk;
    logic rst_a, rst_b, rst_c;
    int   n_checks;
    int   n_errors;
    int   cnt;

    frame_buffer_manager_if #(.H_RES(4), .V_RES(2), .COLOR_BITS(4)) if_a ();
    frame_buffer_manager_if #(.H_RES(4), .V_RES(2), .COLOR_BITS(4)) if_b ();
    frame_buffer_manager_if #(.H_RES(3), .V_RES(2), .COLOR_BITS(4)) if_c ();

    frame_buffer_manager #(.H_RES(4), .V_RES(2), .COLOR_BITS(4), .N_BUFFERS(2),
                           .CLEAR_EN(0), .CLEAR_COLOR(0))
        u_dut_a (.clk(clk), .reset(rst_a), .bus(if_a.slave));
    frame_buffer_manager #(.H_RES(4), .V_RES(2), .COLOR_BITS(4), .N_BUFFERS(2),
                           .CLEAR_EN(1), .CLEAR_COLOR(5))
        u_dut_b (.clk(clk), .reset(rst_b), .bus(if_b.slave));
    frame_buffer_manager #(.H_RES(3), .V_RES(2), .COLOR_BITS(4), .N_BUFFERS(3),
                           .CLEAR_EN(0), .CLEAR_COLOR(0))
        u_dut_c (.clk(clk), .reset(rst_c), .bus(if_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks = n_checks + 1;
        if (obs != exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        if_a.wr_en = 1'b0; if_a.wr_addr = 3'd0; if_a.wr_data = 4'd0; if_a.frame_done = 1'b0;
        if_a.vblank = 1'b0; if_a.rd_x = 2'd0; if_a.rd_y = 1'b0;
        if_b.wr_en = 1'b0; if_b.wr_addr = 3'd0; if_b.wr_data = 4'd0; if_b.frame_done = 1'b0;
        if_b.vblank = 1'b0; if_b.rd_x = 2'd0; if_b.rd_y = 1'b0;
        if_c.wr_en = 1'b0; if_c.wr_addr = 3'd0; if_c.wr_data = 4'd0; if_c.frame_done = 1'b0;
        if_c.vblank = 1'b0; if_c.rd_x = 2'd0; if_c.rd_y = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        tick();
        tick();

        // Reset state
        check_value("a_rst_disp",  32'(if_a.disp_idx),   32'd0);
        check_value("a_rst_back",  32'(if_a.back_idx),   32'd1);
        check_value("a_rst_ready", 32'(if_a.wr_ready),   32'd1);
        check_value("a_rst_swap",  32'(if_a.swap_pulse), 32'd0);
        check_value("a_rst_drop",  32'(if_a.drop_count), 32'd0);
        check_value("a_rst_rdata", 32'(if_a.rd_data),    32'd0);
        check_value("c_rst_back",  32'(if_c.back_idx),   32'd1);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        tick();

        // A: fill back bank 1 with data=addr, then frame_done with vblank low
        for (int i = 0; i < 8; i++) begin
            if_a.wr_en = 1'b1; if_a.wr_addr = 3'(i); if_a.wr_data = 4'(i);
            tick();
        end
        if_a.wr_en = 1'b0; if_a.frame_done = 1'b1;
        tick();
        if_a.frame_done = 1'b0;
        check_value("a_wait_ready", 32'(if_a.wr_ready), 32'd0);
        check_value("a_wait_disp",  32'(if_a.disp_idx), 32'd0);
        // Write while waiting for the swap must be dropped
        if_a.wr_en = 1'b1; if_a.wr_addr = 3'd2; if_a.wr_data = 4'd9;
        tick();
        if_a.wr_en = 1'b0;
        check_value("a_wait_hold", 32'(if_a.wr_ready), 32'd0);
        if_a.vblank = 1'b1;
        tick();
        check_value("a_swap_disp",  32'(if_a.disp_idx),   32'd1);
        check_value("a_swap_back",  32'(if_a.back_idx),   32'd0);
        check_value("a_swap_pulse", 32'(if_a.swap_pulse), 32'd1);
        check_value("a_swap_ready", 32'(if_a.wr_ready),   32'd1);
        tick();
        check_value("a_swap_once",  32'(if_a.swap_pulse), 32'd0);
        check_value("a_vb_level",   32'(if_a.disp_idx),   32'd1);
        if_a.vblank = 1'b0;
        if_a.rd_x = 2'd3; if_a.rd_y = 1'b1;
        tick();
        check_value("a_rd_x3y1", 32'(if_a.rd_data), 32'd7);
        if_a.rd_x = 2'd2; if_a.rd_y = 1'b0;
        tick();
        check_value("a_rd_wait_drop", 32'(if_a.rd_data), 32'd2);

        // A: write, frame_done and vblank rise in the same cycle
        if_a.wr_en = 1'b1; if_a.wr_addr = 3'd5; if_a.wr_data = 4'd11;
        if_a.frame_done = 1'b1; if_a.vblank = 1'b1;
        tick();
        if_a.wr_en = 1'b0; if_a.frame_done = 1'b0; if_a.vblank = 1'b0;
        check_value("a_same_disp",  32'(if_a.disp_idx),   32'd0);
        check_value("a_same_back",  32'(if_a.back_idx),   32'd1);
        check_value("a_same_pulse", 32'(if_a.swap_pulse), 32'd1);
        check_value("a_same_ready", 32'(if_a.wr_ready),   32'd1);
        if_a.rd_x = 2'd1; if_a.rd_y = 1'b1;
        tick();
        check_value("a_same_rd", 32'(if_a.rd_data), 32'd11);

        // B: frame into bank 1, swap, then the clear of bank 0 lasts DEPTH cycles
        for (int i = 0; i < 8; i++) begin
            if_b.wr_en = 1'b1; if_b.wr_addr = 3'(i); if_b.wr_data = 4'(i);
            tick();
        end
        if_b.wr_en = 1'b0; if_b.frame_done = 1'b1;
        tick();
        if_b.frame_done = 1'b0; if_b.vblank = 1'b1;
        tick();
        check_value("b_swap_disp", 32'(if_b.disp_idx), 32'd1);
        check_value("b_swap_back", 32'(if_b.back_idx), 32'd0);
        cnt = 0;
        while (if_b.wr_ready == 1'b0 && cnt < 20) begin
            cnt = cnt + 1;
            tick();
        end
        check_value("b_clear_len", 32'(cnt), 32'd8);
        if_b.vblank = 1'b0;
        if_b.wr_en = 1'b1; if_b.wr_addr = 3'd3; if_b.wr_data = 4'd12;
        tick();
        if_b.wr_addr = 3'd6; if_b.wr_data = 4'd13;
        tick();
        if_b.wr_en = 1'b0; if_b.frame_done = 1'b1;
        tick();
        if_b.frame_done = 1'b0; if_b.vblank = 1'b1;
        tick();
        if_b.vblank = 1'b0;
        check_value("b_swap2_disp", 32'(if_b.disp_idx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            if_b.rd_x = 2'(i % 4); if_b.rd_y = 1'(i / 4);
            tick();
            check_value($sformatf("b_clr_rd%0d", i), 32'(if_b.rd_data),
                        (i == 3) ? 32'd12 : ((i == 6) ? 32'd13 : 32'd5));
        end

        // B: reset in the middle of a clear (count 3)
        cnt = 0;
        while (if_b.wr_ready == 1'b0 && cnt < 20) begin
            cnt = cnt + 1;
            tick();
        end
        check_value("b_clear2_done", 32'(if_b.wr_ready), 32'd1);
        if_b.frame_done = 1'b1;
        tick();
        if_b.frame_done = 1'b0; if_b.vblank = 1'b1;
        tick();
        if_b.vblank = 1'b0;
        check_value("b_pre_rst_disp", 32'(if_b.disp_idx), 32'd1);
        tick(); tick(); tick();
        check_value("b_pre_rst_ready", 32'(if_b.wr_ready), 32'd0);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        check_value("b_rst_disp",  32'(if_b.disp_idx),   32'd0);
        check_value("b_rst_back",  32'(if_b.back_idx),   32'd1);
        check_value("b_rst_ready", 32'(if_b.wr_ready),   32'd1);
        check_value("b_rst_drop",  32'(if_b.drop_count), 32'd0);
        check_value("b_rst_swap",  32'(if_b.swap_pulse), 32'd0);

        // C: triple buffer, two frames without vblank drops the first
        for (int i = 0; i < 6; i++) begin
            if_c.wr_en = 1'b1; if_c.wr_addr = 3'(i); if_c.wr_data = 4'(i);
            tick();
        end
        if_c.wr_en = 1'b0; if_c.frame_done = 1'b1;
        tick();
        if_c.frame_done = 1'b0;
        check_value("c_f1_ready", 32'(if_c.wr_ready),   32'd1);
        check_value("c_f1_back",  32'(if_c.back_idx),   32'd2);
        check_value("c_f1_drop",  32'(if_c.drop_count), 32'd0);
        for (int i = 0; i < 6; i++) begin
            if_c.wr_en = 1'b1; if_c.wr_addr = 3'(i); if_c.wr_data = 4'(10 + i);
            tick();
        end
        if_c.wr_en = 1'b0; if_c.frame_done = 1'b1;
        tick();
        if_c.frame_done = 1'b0;
        check_value("c_f2_ready", 32'(if_c.wr_ready),   32'd1);
        check_value("c_f2_back",  32'(if_c.back_idx),   32'd1);
        check_value("c_f2_drop",  32'(if_c.drop_count), 32'd1);
        check_value("c_f2_disp",  32'(if_c.disp_idx),   32'd0);
        // Out-of-range addresses must not land anywhere
        if_c.wr_en = 1'b1; if_c.wr_addr = 3'd6; if_c.wr_data = 4'd3;
        tick();
        if_c.wr_addr = 3'd7; if_c.wr_data = 4'd4;
        tick();
        if_c.wr_en = 1'b0; if_c.vblank = 1'b1;
        tick();
        if_c.vblank = 1'b0;
        check_value("c_vb_disp",  32'(if_c.disp_idx),   32'd2);
        check_value("c_vb_pulse", 32'(if_c.swap_pulse), 32'd1);
        check_value("c_vb_back",  32'(if_c.back_idx),   32'd1);
        for (int i = 0; i < 6; i++) begin
            if_c.rd_x = 2'(i % 3); if_c.rd_y = 1'(i / 3);
            tick();
            check_value($sformatf("c_rd%0d", i), 32'(if_c.rd_data), 32'(10 + i));
        end
        if_c.rd_x = 2'd3; if_c.rd_y = 1'b0;
        tick();
        check_value("c_rd_x_oob", 32'(if_c.rd_data), 32'd0);
        // vblank with no ready bank changes nothing
        if_c.vblank = 1'b1;
        tick();
        if_c.vblank = 1'b0;
        check_value("c_vb2_disp",  32'(if_c.disp_idx),   32'd2);
        check_value("c_vb2_pulse", 32'(if_c.swap_pulse), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
